// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the DataMemory arbiter.
package dm_arb_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic {
    S_NORM,
    S_FORCE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_EXT
  } owner_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester and memory-side signals of the DataMemory arbiter.
interface dm_arbiter_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
);

  // CPU (MEM stage) port
  logic          cpu_req;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [DW-1:0] cpu_wd;
  logic [DW-1:0] cpu_rd;
  logic          cpu_stall;
  logic          addr_err;

  // EXT (loader/debug) port
  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wd;
  logic          ext_gnt;
  logic          ext_rvalid;
  logic [DW-1:0] ext_rdata;

  // DataMemory port
  logic          DMWE;
  logic [31:0]   DMA;
  logic [DW-1:0] DMWD;
  logic [DW-1:0] DMRD;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd,
    output cpu_rd, cpu_stall, addr_err,
    input  ext_req, ext_we, ext_addr, ext_wd,
    output ext_gnt, ext_rvalid, ext_rdata,
    output DMWE, DMA, DMWD,
    input  DMRD
  );

  // Requesters plus memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd,
    input  cpu_rd, cpu_stall, addr_err,
    output ext_req, ext_we, ext_addr, ext_wd,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  DMWE, DMA, DMWD,
    output DMRD
  );

endinterface

// File: rtl/dm_starve_counter.sv
// Counts consecutive denied EXT cycles and forces one EXT grant after MAX_WAIT.
module dm_starve_counter
  import dm_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic ext_req,
  input  logic ext_gnt,
  output logic force_en
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // State and wait-counter registers
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= S_NORM;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and saturating counter update
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;

    if (!ext_req || ext_gnt) begin
      cnt_nxt = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CNT_W'(1);
    end

    unique case (state)
      S_NORM: begin
        if (ext_req && !ext_gnt && (cnt == CNT_LAST)) begin
          state_nxt = S_FORCE;
        end
      end
      S_FORCE: begin
        // A force window lasts exactly one cycle, used or not
        state_nxt = S_NORM;
      end
      default: state_nxt = S_NORM;
    endcase
  end

  assign force_en = (state == S_FORCE);

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port DataMemory between the MEM stage and the EXT port.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW       = 9,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic         Clk,
  input  logic         Rst_n,
  dm_arbiter_if.slave  bus
);

  owner_t owner;
  logic   force_en;
  logic   in_range;

  assign in_range = (bus.cpu_addr[ADDR_W-1:AW] == '0);

  dm_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .ext_req  (bus.ext_req),
    .ext_gnt  (bus.ext_gnt),
    .force_en (force_en)
  );

  // Owner selection: forced EXT, then CPU, then EXT; nobody during reset
  always_comb begin
    owner = OWN_NONE;
    if (!Rst_n) begin
      owner = OWN_NONE;
    end else if (force_en && bus.ext_req) begin
      owner = OWN_EXT;
    end else if (bus.cpu_req) begin
      owner = OWN_CPU;
    end else if (bus.ext_req) begin
      owner = OWN_EXT;
    end
  end

  // Memory port mux and requester status
  always_comb begin
    bus.DMWE    = 1'b0;
    bus.DMA     = bus.cpu_addr;
    bus.DMWD    = '0;
    bus.ext_gnt = 1'b0;
    bus.cpu_rd  = in_range ? bus.DMRD : '0;

    unique case (owner)
      OWN_CPU: begin
        bus.DMA  = bus.cpu_addr;
        bus.DMWD = bus.cpu_wd;
        bus.DMWE = bus.cpu_we && in_range;
      end
      OWN_EXT: begin
        bus.DMA     = ADDR_W'(bus.ext_addr);
        bus.DMWD    = bus.ext_wd;
        bus.DMWE    = bus.ext_we;
        bus.ext_gnt = 1'b1;
      end
      default: ;
    endcase

    bus.cpu_stall = Rst_n && bus.cpu_req && (owner != OWN_CPU);
  end

  // Registered EXT read return and sticky out-of-range flag
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      bus.ext_rvalid <= 1'b0;
      bus.ext_rdata  <= '0;
      bus.addr_err   <= 1'b0;
    end else begin
      bus.ext_rvalid <= (owner == OWN_EXT) && !bus.ext_we;
      if ((owner == OWN_EXT) && !bus.ext_we) begin
        bus.ext_rdata <= bus.DMRD;
      end
      if ((owner == OWN_CPU) && !in_range) begin
        bus.addr_err <= 1'b1;
      end
    end
  end

endmodule
